// File: rtl/key_sched_pkg.sv
// Shared types, constants and the GF(2^8) doubling helper for the AES-128 key schedule sequencer.
// Optional key reuse on restart is enabled with the KEY_SCHED_REUSE_EN macro (see key_sched_ctrl).
package key_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SUBW,
    EXPAND,
    DONE
  } ks_state_t;

  localparam int NR        = 10;
  localparam int KEY_BYTES = 16;
  localparam int SUBW_CYC  = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [7:0] xtime8(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_rcon_gen.sv
// Round index and round-constant registers for the key schedule.
// Stepping out of round 0 enters round 1 with RCON_INIT; later steps double rcon in GF(2^8).
module key_rcon_gen
  import key_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  output logic [7:0] rcon,
  output logic [3:0] round
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcon  <= RCON_INIT;
      round <= '0;
    end else if (clear) begin
      rcon  <= RCON_INIT;
      round <= '0;
    end else if (step) begin
      round <= round + 4'd1;
      rcon  <= (round == 4'd0) ? RCON_INIT : xtime8(rcon);
    end
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// Sequencer for the byte-serial AES-128 key expansion: load/SubWord/expand FSM, byte counter, S-box arbiter.
// Define KEY_SCHED_REUSE_EN to let start with a stored schedule finish immediately without re-expanding.
module key_sched_ctrl
  import key_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_changed,
  input  logic       user_key_valid,
  output logic       user_key_ready,
  output logic       rk_valid,
  input  logic       rk_ready,
  input  logic       core_req,
  output logic       core_gnt,
  output logic       sb_sel,
  output logic       key_exp_en,
  output logic [4:0] state_counter,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       busy,
  output logic       done,
  output logic       key_stored
);

  localparam logic [4:0] LAST_BYTE  = 5'(KEY_BYTES - 1);
  localparam logic [4:0] SUBW_FIRST = 5'(KEY_BYTES);
  localparam logic [4:0] SUBW_LAST  = 5'(KEY_BYTES + SUBW_CYC - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  ks_state_t  state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       rc_clear, rc_step;
  logic       full_start;
  logic       reuse;
  logic       accept;

`ifdef KEY_SCHED_REUSE_EN
  assign reuse = key_stored;
`else
  assign reuse = 1'b0;
`endif

  assign accept        = user_key_valid && rk_ready;
  assign core_gnt      = core_req && (state != SUBW);
  assign state_counter = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      key_stored <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (key_changed || full_start)
        key_stored <= 1'b0;
      else if (state == DONE)
        key_stored <= 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    rc_clear       = 1'b0;
    rc_step        = 1'b0;
    full_start     = 1'b0;
    user_key_ready = 1'b0;
    rk_valid       = 1'b0;
    key_exp_en     = 1'b0;
    sb_sel         = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          if (reuse) begin
            state_nxt = DONE;
          end else begin
            state_nxt  = LOAD;
            cnt_nxt    = '0;
            rc_clear   = 1'b1;
            full_start = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        busy           = 1'b1;
        user_key_ready = rk_ready;
        rk_valid       = user_key_valid;
        key_exp_en     = accept;
        if (accept) begin
          if (cnt == LAST_BYTE) begin
            state_nxt = SUBW;
            cnt_nxt   = SUBW_FIRST;
            rc_step   = 1'b1;
          end else begin
            cnt_nxt = cnt + 5'd1;
          end
        end
      end
      SUBW: begin
        busy       = 1'b1;
        sb_sel     = 1'b1;
        key_exp_en = 1'b1;
        if (cnt == SUBW_LAST) begin
          state_nxt = EXPAND;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      EXPAND: begin
        busy       = 1'b1;
        rk_valid   = 1'b1;
        key_exp_en = rk_ready;
        if (rk_ready) begin
          if (cnt != LAST_BYTE) begin
            cnt_nxt = cnt + 5'd1;
          end else if (round == LAST_ROUND) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = SUBW;
            cnt_nxt   = SUBW_FIRST;
            rc_step   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // An abort overrides whatever the current state decided, including a same-cycle start.
    if (key_changed) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      rc_clear   = 1'b1;
      rc_step    = 1'b0;
      full_start = 1'b0;
    end
  end

  key_rcon_gen u_rcon (
    .clk   (clk),
    .rst   (rst),
    .clear (rc_clear),
    .step  (rc_step),
    .rcon  (rcon),
    .round (round)
  );

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: progress-based reference model compared every cycle,
// plus directed runs with hand-computed latencies (nominal, back-pressure, abort, reuse, reset).
module tb_key_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, key_changed = 1'b0, user_key_valid = 1'b0, rk_ready = 1'b0, core_req = 1'b0;
  logic       user_key_ready, rk_valid, core_gnt, sb_sel, key_exp_en, busy, done, key_stored;
  logic [4:0] state_counter;
  logic [7:0] rcon;
  logic [3:0] round;

  always #5 clk = ~clk;

  key_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key_changed(key_changed),
    .user_key_valid(user_key_valid), .user_key_ready(user_key_ready),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .core_req(core_req), .core_gnt(core_gnt),
    .sb_sel(sb_sel), .key_exp_en(key_exp_en), .state_counter(state_counter),
    .rcon(rcon), .round(round), .busy(busy), .done(done), .key_stored(key_stored)
  );

`ifdef KEY_SCHED_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a single progress index. 0..15 are key bytes loaded,
  // 16..215 are 10 rounds of 20 slots (4 SubWord then 16 expand), 216 is the done cycle.
  localparam int LOAD_N  = 16;
  localparam int ROUND_N = 20;
  localparam int END_P   = LOAD_N + 10 * ROUND_N;
  logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  bit         m_run, m_stored;
  int         m_prog, m_idle_round;
  logic [7:0] m_idle_rcon;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_prog = 0; m_stored = 0; m_idle_rcon = 8'h01; m_idle_round = 0;
    end else if (key_changed) begin
      m_run = 0; m_stored = 0; m_idle_rcon = 8'h01; m_idle_round = 0;
    end else if (!m_run || m_prog == END_P) begin
      if (start) begin
        if (REUSE && m_stored) begin
          m_run = 1; m_prog = END_P;
        end else begin
          m_run = 1; m_prog = 0; m_stored = 0;
        end
      end else if (m_run) begin
        m_run = 0; m_stored = 1; m_idle_rcon = 8'h36; m_idle_round = 10;
      end
    end else if (m_prog < LOAD_N) begin
      if (user_key_valid && rk_ready) m_prog++;
    end else if (((m_prog - LOAD_N) % ROUND_N) < 4) begin
      m_prog++;
    end else if (rk_ready) begin
      m_prog++;
    end
  end

  bit         chk_en = 0;
  logic       e_ukr, e_rkv, e_gnt, e_sb, e_en, e_busy, e_done;
  logic [4:0] e_cnt;
  logic [7:0] e_rcon;
  int         e_round, k, w, r;

  always @(negedge clk) begin
    if (chk_en) begin
      e_ukr = 0; e_rkv = 0; e_gnt = core_req; e_sb = 0; e_en = 0; e_busy = 0; e_done = 0;
      e_cnt = 0; e_rcon = m_idle_rcon; e_round = m_idle_round;
      if (rst && m_run) begin
        if (m_prog == END_P) begin
          e_done = 1; e_rcon = 8'h36; e_round = 10;
        end else if (m_prog < LOAD_N) begin
          e_busy = 1; e_cnt = 5'(m_prog); e_rcon = 8'h01; e_round = 0;
          e_ukr = rk_ready; e_rkv = user_key_valid; e_en = user_key_valid && rk_ready;
        end else begin
          k = m_prog - LOAD_N; r = k / ROUND_N; w = k % ROUND_N;
          e_busy = 1; e_round = r + 1; e_rcon = rcon_tab[r];
          if (w < 4) begin
            e_cnt = 5'(16 + w); e_sb = 1; e_en = 1; e_gnt = 0;
          end else begin
            e_cnt = 5'(w - 4); e_rkv = 1; e_en = rk_ready;
          end
        end
      end
      check("model user_key_ready", 32'(user_key_ready), 32'(e_ukr));
      check("model rk_valid", 32'(rk_valid), 32'(e_rkv));
      check("model core_gnt", 32'(core_gnt), 32'(e_gnt));
      check("model sb_sel", 32'(sb_sel), 32'(e_sb));
      check("model key_exp_en", 32'(key_exp_en), 32'(e_en));
      check("model busy", 32'(busy), 32'(e_busy));
      check("model done", 32'(done), 32'(e_done));
      check("model state_counter", 32'(state_counter), 32'(e_cnt));
      check("model rcon", 32'(rcon), 32'(e_rcon));
      check("model round", 32'(round), 32'(e_round));
      check("model key_stored", 32'(key_stored), 32'(m_stored));
    end
  end

  // One start pulse, then watch until done (or an abort settles). Optional stall/abort hooks.
  task automatic run(input int stall_round, input int stall_cnt, input int abort_round,
                     output int cyc, output int gnt_low, output bit saw_done, output bit busy_seen,
                     output logic [7:0] rcon_r9, output logic [7:0] rcon_r10);
    int  left = 0;
    bit  stalled = 0, aborted = 0;
    int  after_abort = 0;
    cyc = 0; gnt_low = 0; saw_done = 0; busy_seen = 0; rcon_r9 = 8'h00; rcon_r10 = 8'h00;
    @(posedge clk); #2 start = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      start = 1'b0; key_changed = 1'b0;
      cyc = i;
      if (!core_gnt) gnt_low++;
      if (busy) busy_seen = 1;
      if (round == 4'd9) rcon_r9 = rcon;
      if (round == 4'd10) rcon_r10 = rcon;
      if (done) begin saw_done = 1; break; end
      if (aborted) begin
        if (after_abort == 0) begin
          check("abort busy", 32'(busy), 32'd0);
          check("abort key_stored", 32'(key_stored), 32'd0);
          check("abort round", 32'(round), 32'd0);
          check("abort rcon", 32'(rcon), 32'h01);
        end
        after_abort++;
        if (after_abort >= 30) break;
        continue;
      end
      if (left > 0 || (stalled && !rk_ready)) begin
        check("stall counter hold", 32'(state_counter), 32'(stall_cnt));
        if (left == 0) rk_ready = 1'b1; else left--;
      end else if (stall_round > 0 && !stalled && busy && !sb_sel &&
                   round == 4'(stall_round) && state_counter == 5'(stall_cnt)) begin
        stalled = 1; rk_ready = 1'b0; left = 4;
        start = 1'b1;
      end
      if (abort_round > 0 && busy && !sb_sel && round == 4'(abort_round)) begin
        key_changed = 1'b1; aborted = 1;
      end
    end
    rk_ready = 1'b1;
  endtask

  int         cyc, gnt_low;
  bit         saw_done, busy_seen;
  logic [7:0] r9, r10;

  initial begin
    #2 rst = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset rcon", 32'(rcon), 32'h01);
    check("reset round", 32'(round), 32'd0);
    check("reset counter", 32'(state_counter), 32'd0);
    check("reset key_stored", 32'(key_stored), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    chk_en = 1;
    user_key_valid = 1'b1; rk_ready = 1'b1; core_req = 1'b1;

    run(0, 0, 0, cyc, gnt_low, saw_done, busy_seen, r9, r10);
    check("nominal done seen", 32'(saw_done), 32'd1);
    check("nominal latency", 32'(cyc), 32'd217);
    check("arbitration gnt low cycles", 32'(gnt_low), 32'd40);
    check("nominal rcon round 9", 32'(r9), 32'h1b);
    check("nominal rcon round 10", 32'(r10), 32'h36);
    @(posedge clk); #1;
    check("nominal key_stored after", 32'(key_stored), 32'd1);

    run(0, 0, 0, cyc, gnt_low, saw_done, busy_seen, r9, r10);
    check("restart done seen", 32'(saw_done), 32'd1);
    check("restart latency", 32'(cyc), REUSE ? 32'd1 : 32'd217);
    check("restart busy seen", 32'(busy_seen), REUSE ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    check("restart key_stored", 32'(key_stored), 32'd1);

    #1 key_changed = 1'b1;
    @(posedge clk); #1 key_changed = 1'b0;
    check("key_changed clears stored", 32'(key_stored), 32'd0);

    run(3, 7, 0, cyc, gnt_low, saw_done, busy_seen, r9, r10);
    check("backpressure done seen", 32'(saw_done), 32'd1);
    check("backpressure latency", 32'(cyc), 32'd222);

    run(0, 0, 6, cyc, gnt_low, saw_done, busy_seen, r9, r10);
    check("abort no done", 32'(saw_done), 32'd0);

    #1 start = 1'b1; key_changed = 1'b1;
    @(posedge clk); #1 start = 1'b0; key_changed = 1'b0;
    check("start with key_changed stays idle", 32'(busy), 32'd0);

    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (round == 4'd2 && busy && !sb_sel) break;
      @(posedge clk); #1;
    end
    check("reached round 2 expand", 32'(round), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("midrun reset busy", 32'(busy), 32'd0);
    check("midrun reset rcon", 32'(rcon), 32'h01);
    check("midrun reset round", 32'(round), 32'd0);
    check("midrun reset counter", 32'(state_counter), 32'd0);
    check("midrun reset rk_valid", 32'(rk_valid), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("no restart without start", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
